// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   One requester's connection to the data-memory arbiter. It carries the
//   request/grant handshake, the access payload and the load-return path.
//
//   Signals
//     req     requester -> arbiter  access request, held until gnt
//     we      requester -> arbiter  1 = store, 0 = load
//     addr    requester -> arbiter  physical byte address
//     wdata   requester -> arbiter  store data
//     gnt     arbiter -> requester  access performed this cycle
//     stall   arbiter -> requester  req & ~gnt (the core holds its PC on this)
//     rvalid  arbiter -> requester  load data valid (cycle after a load grant)
//     rdata   arbiter -> requester  registered load data
//
//   Modports
//     master  requester side
//     slave   arbiter side
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              stall;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, stall, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, stall, rvalid, rdata
    );

endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single data-memory port between the CPU load/store path and a
//   second requester (DEV: debug loader / DMA). At most one access per clock.
//   The grant is sticky: the current owner keeps the port while it keeps
//   requesting, but once it has taken MAX_BURST consecutive grants and the
//   other side is also waiting, ownership is handed over so neither starves.
//
//   Parameters
//     ADDR_W     physical byte address width
//     DATA_W     data word width
//     MAX_BURST  max consecutive grants to one owner under contention (>= 1)
//
//   Ports
//     clk         system clock, all state updates on posedge
//     rst         synchronous, active-high reset
//     cpu         CPU requester (dmem_arbiter_if.slave)
//     dev         DEV requester (dmem_arbiter_if.slave)
//     mem_addr_o  RAM address
//     mem_din_o   RAM write data
//     mem_str_o   RAM write strobe (sampled by the RAM at posedge)
//     mem_ld_o    RAM load enable
//     mem_dout_i  RAM read data (valid combinationally while mem_ld_o = 1)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     cpu,
    dmem_arbiter_if.slave     dev,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_din_o,
    output logic              mem_str_o,
    output logic              mem_ld_o,
    input  logic [DATA_W-1:0] mem_dout_i
);

    // Burst counter must be able to hold MAX_BURST itself (it saturates there).
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DEV  = 2'd2
    } own_t;

    typedef enum logic {
        WIN_CPU = 1'b0,
        WIN_DEV = 1'b1
    } win_t;

    own_t              own_q, own_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    win_t              last_win_q, last_win_d;
    logic              rv_cpu_q, rv_cpu_d;
    logic              rv_dev_q, rv_dev_d;
    logic [DATA_W-1:0] rdata_cpu_q, rdata_cpu_d;
    logic [DATA_W-1:0] rdata_dev_q, rdata_dev_d;

    logic              cpu_gnt_s;
    logic              dev_gnt_s;
    logic [BW-1:0]     burst_inc_s;

    // Saturating increment: a solo owner may run far past the cap, but the
    // counter only needs to remember "cap reached".
    assign burst_inc_s = (burst_cnt_q >= BURST_MAX) ? BURST_MAX : (burst_cnt_q + BURST_ONE);

    // Grant decision: one winner per cycle, nothing granted while in reset.
    always_comb begin
        cpu_gnt_s = 1'b0;
        dev_gnt_s = 1'b0;
        if (rst) begin
            cpu_gnt_s = 1'b0;
            dev_gnt_s = 1'b0;
        end else if (cpu.req && dev.req) begin
            case (own_q)
                OWN_CPU: begin
                    if (burst_cnt_q < BURST_MAX) begin
                        cpu_gnt_s = 1'b1;
                    end else begin
                        dev_gnt_s = 1'b1;
                    end
                end
                OWN_DEV: begin
                    if (burst_cnt_q < BURST_MAX) begin
                        dev_gnt_s = 1'b1;
                    end else begin
                        cpu_gnt_s = 1'b1;
                    end
                end
                OWN_IDLE: begin
                    // Fresh contention: the side that did not win last goes first.
                    if (last_win_q == WIN_DEV) begin
                        cpu_gnt_s = 1'b1;
                    end else begin
                        dev_gnt_s = 1'b1;
                    end
                end
                default: begin
                    if (last_win_q == WIN_DEV) begin
                        cpu_gnt_s = 1'b1;
                    end else begin
                        dev_gnt_s = 1'b1;
                    end
                end
            endcase
        end else if (cpu.req) begin
            cpu_gnt_s = 1'b1;
        end else if (dev.req) begin
            dev_gnt_s = 1'b1;
        end else begin
            cpu_gnt_s = 1'b0;
            dev_gnt_s = 1'b0;
        end
    end

    // Ownership / burst bookkeeping for the next cycle.
    always_comb begin
        own_d       = own_q;
        burst_cnt_d = burst_cnt_q;
        last_win_d  = last_win_q;
        if (cpu_gnt_s) begin
            own_d       = OWN_CPU;
            last_win_d  = WIN_CPU;
            burst_cnt_d = (own_q == OWN_CPU) ? burst_inc_s : BURST_ONE;
        end else if (dev_gnt_s) begin
            own_d       = OWN_DEV;
            last_win_d  = WIN_DEV;
            burst_cnt_d = (own_q == OWN_DEV) ? burst_inc_s : BURST_ONE;
        end else begin
            // An idle cycle ends any burst; last_win is kept for the next tie.
            own_d       = OWN_IDLE;
            burst_cnt_d = {BW{1'b0}};
        end
    end

    // Memory port mux: the granted side drives the RAM, otherwise all zero.
    always_comb begin
        mem_addr_o = {ADDR_W{1'b0}};
        mem_din_o  = {DATA_W{1'b0}};
        mem_str_o  = 1'b0;
        mem_ld_o   = 1'b0;
        if (cpu_gnt_s) begin
            mem_addr_o = cpu.addr;
            mem_din_o  = cpu.wdata;
            mem_str_o  = cpu.we;
            mem_ld_o   = ~cpu.we;
        end else if (dev_gnt_s) begin
            mem_addr_o = dev.addr;
            mem_din_o  = dev.wdata;
            mem_str_o  = dev.we;
            mem_ld_o   = ~dev.we;
        end else begin
            mem_addr_o = {ADDR_W{1'b0}};
            mem_din_o  = {DATA_W{1'b0}};
            mem_str_o  = 1'b0;
            mem_ld_o   = 1'b0;
        end
    end

    // Load return path: capture RAM data on a load grant, pulse rvalid once.
    always_comb begin
        rv_cpu_d    = cpu_gnt_s & ~cpu.we;
        rv_dev_d    = dev_gnt_s & ~dev.we;
        rdata_cpu_d = rdata_cpu_q;
        rdata_dev_d = rdata_dev_q;
        if (rv_cpu_d) begin
            rdata_cpu_d = mem_dout_i;
        end else begin
            rdata_cpu_d = rdata_cpu_q;
        end
        if (rv_dev_d) begin
            rdata_dev_d = mem_dout_i;
        end else begin
            rdata_dev_d = rdata_dev_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            own_q       <= OWN_IDLE;
            burst_cnt_q <= {BW{1'b0}};
            last_win_q  <= WIN_DEV;
            rv_cpu_q    <= 1'b0;
            rv_dev_q    <= 1'b0;
            rdata_cpu_q <= {DATA_W{1'b0}};
            rdata_dev_q <= {DATA_W{1'b0}};
        end else begin
            own_q       <= own_d;
            burst_cnt_q <= burst_cnt_d;
            last_win_q  <= last_win_d;
            rv_cpu_q    <= rv_cpu_d;
            rv_dev_q    <= rv_dev_d;
            rdata_cpu_q <= rdata_cpu_d;
            rdata_dev_q <= rdata_dev_d;
        end
    end

    assign cpu.gnt    = cpu_gnt_s;
    assign dev.gnt    = dev_gnt_s;
    assign cpu.stall  = cpu.req & ~cpu_gnt_s;
    assign dev.stall  = dev.req & ~dev_gnt_s;
    assign cpu.rvalid = rv_cpu_q;
    assign dev.rvalid = rv_dev_q;
    assign cpu.rdata  = rdata_cpu_q;
    assign dev.rdata  = rdata_dev_q;

    dmem_arbiter_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu.req),
        .cpu_gnt   (cpu_gnt_s),
        .cpu_stall (cpu.req & ~cpu_gnt_s),
        .dev_gnt   (dev_gnt_s),
        .mem_str   (mem_str_o),
        .mem_ld    (mem_ld_o)
    );

endmodule

// -----------------------------------------------------------------------------
// dmem_arbiter_chk
//   Invariant checks for the arbiter: single grant, exclusive strobes, quiet
//   memory port during reset, stall consistent with request/grant.
// -----------------------------------------------------------------------------
module dmem_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic cpu_req,
    input logic cpu_gnt,
    input logic cpu_stall,
    input logic dev_gnt,
    input logic mem_str,
    input logic mem_ld
);

    a_one_grant:  assert property (@(posedge clk) !(cpu_gnt && dev_gnt));
    a_str_ld_exc: assert property (@(posedge clk) !(mem_str && mem_ld));
    a_rst_quiet:  assert property (@(posedge clk) rst |-> (!mem_str && !mem_ld && !cpu_gnt && !dev_gnt));
    a_stall:      assert property (@(posedge clk) cpu_stall == (cpu_req && !cpu_gnt));

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int ADDR_W    = 11;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_str;
    logic              mem_ld;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_bus ();
    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dev_bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu        (cpu_bus),
        .dev        (dev_bus),
        .mem_addr_o (mem_addr),
        .mem_din_o  (mem_din),
        .mem_str_o  (mem_str),
        .mem_ld_o   (mem_ld),
        .mem_dout_i (mem_dout)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: write at posedge on str, combinational read.
    logic [DATA_W-1:0] ram [DEPTH];
    bit                ram_ready = 1'b0;

    function automatic logic [DATA_W-1:0] init_word(input int a);
        return (DATA_W'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else if (mem_str) begin
            ram[mem_addr] <= mem_din;
        end
    end

    assign mem_dout = ram[mem_addr];

    // Reference model state: grant history since reset, last winner, expected
    // RAM contents and expected load returns.
    int                n_checks = 0;
    int                n_fail   = 0;
    int                hist[$];
    int                last_win;
    int                last_g;
    bit                obs_cg, obs_dg;
    bit                exp_rv_cpu, exp_rv_dev;
    logic [DATA_W-1:0] exp_rd_cpu, exp_rd_dev;
    logic [DATA_W-1:0] shadow [DEPTH];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Who should win this cycle: 0 none, 1 CPU, 2 DEV.
    function automatic int predict(input bit r, input bit c, input bit d);
        int prev;
        int streak;
        if (r || (!c && !d)) return 0;
        if (c && !d) return 1;
        if (d && !c) return 2;
        prev = (hist.size() > 0) ? hist[hist.size()-1] : 0;
        if (prev == 0) return (last_win == 1) ? 2 : 1;
        streak = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != prev) break;
            streak++;
        end
        return (streak < MAX_BURST) ? prev : 3 - prev;
    endfunction

    // One clock: check combinational outputs mid-cycle, advance the model at
    // the edge, then check the registered load-return outputs.
    task automatic cycle_check();
        int                g;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        bit                es, el;
        @(negedge clk);
        g  = predict(rst, cpu_bus.req, dev_bus.req);
        ea = '0; ed = '0; es = 1'b0; el = 1'b0;
        if (g == 1) begin
            ea = cpu_bus.addr; ed = cpu_bus.wdata; es = cpu_bus.we; el = !cpu_bus.we;
        end else if (g == 2) begin
            ea = dev_bus.addr; ed = dev_bus.wdata; es = dev_bus.we; el = !dev_bus.we;
        end
        obs_cg = cpu_bus.gnt;
        obs_dg = dev_bus.gnt;
        check_eq("cpu_gnt",   cpu_bus.gnt,   g == 1);
        check_eq("dev_gnt",   dev_bus.gnt,   g == 2);
        check_eq("cpu_stall", cpu_bus.stall, cpu_bus.req && (g != 1));
        check_eq("mem_str",   mem_str,       es);
        check_eq("mem_ld",    mem_ld,        el);
        check_eq("mem_addr",  mem_addr,      ea);
        check_eq("mem_din",   mem_din,       ed);
        @(posedge clk);
        #1;
        if (rst) begin
            hist.delete();
            last_win   = 2;
            exp_rv_cpu = 1'b0;
            exp_rv_dev = 1'b0;
            exp_rd_cpu = '0;
            exp_rd_dev = '0;
        end else begin
            hist.push_back(g);
            if (hist.size() > 64) void'(hist.pop_front());
            if (g != 0) last_win = g;
            exp_rv_cpu = (g == 1) && !cpu_bus.we;
            exp_rv_dev = (g == 2) && !dev_bus.we;
            if (exp_rv_cpu) exp_rd_cpu = shadow[cpu_bus.addr];
            if (exp_rv_dev) exp_rd_dev = shadow[dev_bus.addr];
            if (g == 1 && cpu_bus.we) shadow[cpu_bus.addr] = cpu_bus.wdata;
            if (g == 2 && dev_bus.we) shadow[dev_bus.addr] = dev_bus.wdata;
        end
        last_g = g;
        check_eq("cpu_rvalid", cpu_bus.rvalid, exp_rv_cpu);
        check_eq("dev_rvalid", dev_bus.rvalid, exp_rv_dev);
        check_eq("cpu_rdata",  cpu_bus.rdata,  exp_rd_cpu);
        check_eq("dev_rdata",  dev_bus.rdata,  exp_rd_dev);
    endtask

    task automatic set_cpu(input bit r, input bit w, input int a, input logic [DATA_W-1:0] d);
        cpu_bus.req = r; cpu_bus.we = w; cpu_bus.addr = ADDR_W'(a); cpu_bus.wdata = d;
    endtask

    task automatic set_dev(input bit r, input bit w, input int a, input logic [DATA_W-1:0] d);
        dev_bus.req = r; dev_bus.we = w; dev_bus.addr = ADDR_W'(a); dev_bus.wdata = d;
    endtask

    task automatic idle_cycle();
        set_cpu(1'b0, 1'b0, 0, '0);
        set_dev(1'b0, 1'b0, 0, '0);
        cycle_check();
    endtask

    // Random requesters: a new transaction only once the previous one is granted.
    task automatic rand_drive(input int pc, input int pd);
        if (!cpu_bus.req || last_g == 1) begin
            if ($urandom_range(99) < pc) set_cpu(1'b1, 1'($urandom_range(1)), $urandom_range(31), $urandom());
            else set_cpu(1'b0, 1'b0, 0, '0);
        end
        if (!dev_bus.req || last_g == 2) begin
            if ($urandom_range(99) < pd) set_dev(1'b1, 1'($urandom_range(1)), $urandom_range(31), $urandom());
            else set_dev(1'b0, 1'b0, 0, '0);
        end
    endtask

    initial begin
        int nbad;
        int pc, pd;
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
        hist.delete();
        last_win   = 2;
        last_g     = 0;
        exp_rv_cpu = 1'b0;
        exp_rv_dev = 1'b0;
        exp_rd_cpu = '0;
        exp_rd_dev = '0;

        // 1: reset with both requesting, then CPU wins the first tie.
        rst = 1'b1;
        set_cpu(1'b1, 1'b0, 5, '0);
        set_dev(1'b1, 1'b0, 6, '0);
        cycle_check();
        cycle_check();
        rst = 1'b0;
        cycle_check();
        check_eq("t1_first_tie_cpu", obs_cg, 1'b1);
        idle_cycle();

        // 2: DEV preloads 0xDEADBEEF, then a solo CPU load returns it once.
        set_dev(1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF);
        cycle_check();
        set_dev(1'b0, 1'b0, 0, '0);
        set_cpu(1'b1, 1'b0, 12'h010, '0);
        cycle_check();
        check_eq("t2_gnt", obs_cg, 1'b1);
        check_eq("t2_rvalid", cpu_bus.rvalid, 1'b1);
        check_eq("t2_rdata", cpu_bus.rdata, 32'hDEAD_BEEF);
        set_cpu(1'b0, 1'b0, 0, '0);
        cycle_check();
        check_eq("t2_rvalid_once", cpu_bus.rvalid, 1'b0);

        // 3: continuous contention from reset: CPU x4, DEV x4, ...
        rst = 1'b1;
        cycle_check();
        rst = 1'b0;
        set_cpu(1'b1, 1'b0, $urandom_range(31), '0);
        set_dev(1'b1, 1'b0, $urandom_range(31), '0);
        for (int k = 0; k < 16; k++) begin
            cycle_check();
            check_eq("t3_pattern", obs_cg, ((k / 4) % 2) == 0);
            if (obs_cg) cpu_bus.addr = ADDR_W'($urandom_range(31));
            if (obs_dg) dev_bus.addr = ADDR_W'($urandom_range(31));
        end
        idle_cycle();

        // 4: DEV alone for 10 cycles, then CPU arrives and wins at once.
        for (int k = 0; k < 10; k++) begin
            set_dev(1'b1, 1'b0, $urandom_range(31), '0);
            cycle_check();
            check_eq("t4_dev_solo", obs_dg, 1'b1);
        end
        set_cpu(1'b1, 1'b0, 3, '0);
        cycle_check();
        check_eq("t4_cpu_takes", obs_cg, 1'b1);
        set_cpu(1'b0, 1'b0, 0, '0);
        cycle_check();
        idle_cycle();

        // 5: DEV store then CPU load of the same address.
        set_dev(1'b1, 1'b1, 12'h020, 32'h1234_5678);
        cycle_check();
        set_dev(1'b0, 1'b0, 0, '0);
        set_cpu(1'b1, 1'b0, 12'h020, '0);
        cycle_check();
        check_eq("t5_rdata", cpu_bus.rdata, 32'h1234_5678);
        idle_cycle();

        // 6: reset right after a load grant; a store during reset is dropped.
        set_cpu(1'b1, 1'b0, 12'h010, '0);
        cycle_check();
        rst = 1'b1;
        set_cpu(1'b0, 1'b0, 0, '0);
        set_dev(1'b1, 1'b1, 12'h030, 32'hA5A5_A5A5);
        cycle_check();
        check_eq("t6_rvalid_cleared", cpu_bus.rvalid, 1'b0);
        check_eq("t6_ram_untouched", ram[12'h030], init_word(12'h030));
        rst = 1'b0;
        idle_cycle();

        // Random traffic with occasional resets and varying load.
        for (int n = 0; n < 800; n++) begin
            pc = (n < 400) ? 70 : 95;
            pd = (n < 400) ? 60 : 95;
            rst = ($urandom_range(99) < 2);
            rand_drive(pc, pd);
            cycle_check();
        end
        rst = 1'b0;
        idle_cycle();

        nbad = 0;
        for (int a = 0; a < 64; a++) begin
            if (ram[a] !== shadow[a]) nbad++;
        end
        check_eq("ram_contents", nbad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
